// File: rtl/power_rail_sequencer_if.sv
// Handshake bundle between a supply-domain controller and power_rail_sequencer:
// the request/power-good inputs and the regulator-enable/status outputs.
interface power_rail_sequencer_if #(
    parameter int NUM_RAILS = 4
);
    logic                 enable;
    logic [NUM_RAILS-1:0] pg;
    logic [NUM_RAILS-1:0] en;
    logic                 power_good;
    logic                 fault;
    logic [3:0]           fault_rail;
    logic [2:0]           state;

    modport master (
        output enable, pg,
        input  en, power_good, fault, fault_rail, state
    );

    modport slave (
        input  enable, pg,
        output en, power_good, fault, fault_rail, state
    );
endinterface

// File: rtl/power_rail_sequencer.sv
// N-rail power sequencer: enables regulators in index order gated on power-good
// plus settle time, monitors them while up, and disables them in reverse order.
module power_rail_sequencer #(
    parameter int NUM_RAILS      = 4,
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 16384,
    parameter int SETTLE_CYCLES  = 256,
    parameter int OFF_CYCLES     = 256
) (
    input  logic                   sysclk,
    input  logic                   reset,
    power_rail_sequencer_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RAMP     = 3'd1,
        SETTLE   = 3'd2,
        RUN      = 3'd3,
        SHUTDOWN = 3'd4,
        FAULT    = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] OFF_LAST     = CNT_W'(OFF_CYCLES - 1);
    localparam logic [3:0]       LAST_RAIL    = 4'(NUM_RAILS - 1);
    localparam logic [NUM_RAILS-1:0] RAIL0    = {{(NUM_RAILS-1){1'b0}}, 1'b1};

    function automatic logic bit_at(input logic [NUM_RAILS-1:0] vec, input logic [3:0] sel);
        logic r;
        r = 1'b0;
        for (int j = 0; j < NUM_RAILS; j++) begin
            r = r | (vec[j] & (4'(j) == sel));
        end
        return r;
    endfunction

    function automatic logic [NUM_RAILS-1:0] rail_bit(input logic [3:0] sel);
        logic [NUM_RAILS-1:0] m;
        for (int j = 0; j < NUM_RAILS; j++) begin
            m[j] = (4'(j) == sel);
        end
        return m;
    endfunction

    // Returns {hit, index} of the lowest rail below limit whose power-good is low.
    function automatic logic [4:0] lowest_low(input logic [NUM_RAILS-1:0] vec, input logic [4:0] limit);
        logic       hit;
        logic [3:0] pos;
        logic       c;
        hit = 1'b0;
        pos = 4'd0;
        for (int j = NUM_RAILS - 1; j >= 0; j--) begin
            c   = (5'(j) < limit) & ~vec[j];
            hit = hit | c;
            pos = c ? 4'(j) : pos;
        end
        return {hit, pos};
    endfunction

    function automatic logic [3:0] highest_set(input logic [NUM_RAILS-1:0] vec);
        logic [3:0] pos;
        pos = 4'd0;
        for (int j = 0; j < NUM_RAILS; j++) begin
            pos = vec[j] ? 4'(j) : pos;
        end
        return pos;
    endfunction

    state_t               state_q, state_d;
    logic [3:0]           idx_q, idx_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [NUM_RAILS-1:0] en_q, en_d;
    logic [NUM_RAILS-1:0] pg_meta_q, pg_meta_d;
    logic [NUM_RAILS-1:0] pg_s_q, pg_s_d;
    logic                 power_good_q, power_good_d;
    logic                 fault_q, fault_d;
    logic [3:0]           fault_rail_q, fault_rail_d;

    logic [4:0] loss_ramp_s, loss_settle_s, loss_run_s;
    logic       cur_pg_s;
    logic [3:0] down_idx_s;
    logic       go_fault_s, go_down_s;
    logic [3:0] fault_idx_s;

    // While ramping only rails below idx are expected up; once settling, idx is too.
    assign loss_ramp_s   = lowest_low(pg_s_q, {1'b0, idx_q});
    assign loss_settle_s = lowest_low(pg_s_q, {1'b0, idx_q} + 5'd1);
    assign loss_run_s    = lowest_low(pg_s_q, 5'(NUM_RAILS));
    assign cur_pg_s      = bit_at(pg_s_q, idx_q);
    assign down_idx_s    = highest_set(en_q);

    // Next-state and next-output logic for the sequencer.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        en_d         = en_q;
        power_good_d = power_good_q;
        fault_d      = fault_q;
        fault_rail_d = fault_rail_q;
        pg_meta_d    = bus.pg;
        pg_s_d       = pg_meta_q;
        go_fault_s   = 1'b0;
        go_down_s    = 1'b0;
        fault_idx_s  = 4'd0;

        case (state_q)
            IDLE: begin
                en_d = '0;
                if (bus.enable) begin
                    state_d = RAMP;
                    idx_d   = 4'd0;
                    cnt_d   = '0;
                    en_d    = RAIL0;
                end else begin
                    state_d = IDLE;
                end
            end
            RAMP: begin
                if (loss_ramp_s[4]) begin
                    go_fault_s  = 1'b1;
                    fault_idx_s = loss_ramp_s[3:0];
                end else if (!bus.enable) begin
                    go_down_s = 1'b1;
                end else if (cur_pg_s) begin
                    state_d = SETTLE;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    go_fault_s  = 1'b1;
                    fault_idx_s = idx_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SETTLE: begin
                if (loss_settle_s[4]) begin
                    go_fault_s  = 1'b1;
                    fault_idx_s = loss_settle_s[3:0];
                end else if (!bus.enable) begin
                    go_down_s = 1'b1;
                end else if (cnt_q == SETTLE_LAST) begin
                    cnt_d = '0;
                    if (idx_q == LAST_RAIL) begin
                        state_d      = RUN;
                        power_good_d = 1'b1;
                    end else begin
                        state_d = RAMP;
                        idx_d   = idx_q + 4'd1;
                        en_d    = en_q | rail_bit(idx_q + 4'd1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RUN: begin
                if (loss_run_s[4]) begin
                    go_fault_s  = 1'b1;
                    fault_idx_s = loss_run_s[3:0];
                end else if (!bus.enable) begin
                    go_down_s = 1'b1;
                end else begin
                    state_d = RUN;
                end
            end
            SHUTDOWN: begin
                power_good_d = 1'b0;
                if (cnt_q == OFF_LAST) begin
                    cnt_d = '0;
                    if (idx_q == 4'd0) begin
                        state_d = fault_q ? FAULT : IDLE;
                    end else begin
                        idx_d = idx_q - 4'd1;
                        en_d  = en_q & ~rail_bit(idx_q - 4'd1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            FAULT: begin
                en_d    = '0;
                fault_d = 1'b1;
                if (!bus.enable) begin
                    state_d = IDLE;
                    fault_d = 1'b0;
                end else begin
                    state_d = FAULT;
                end
            end
            default: begin
                state_d      = IDLE;
                idx_d        = 4'd0;
                cnt_d        = '0;
                en_d         = '0;
                power_good_d = 1'b0;
            end
        endcase

        if (go_fault_s) begin
            fault_d      = 1'b1;
            fault_rail_d = fault_idx_s;
        end else begin
            fault_d = fault_d;
        end

        // Both fault and request-off start the reverse walk from the highest enabled rail.
        if (go_fault_s || go_down_s) begin
            state_d      = SHUTDOWN;
            power_good_d = 1'b0;
            idx_d        = down_idx_s;
            en_d         = en_q & ~rail_bit(down_idx_s);
            cnt_d        = '0;
        end else begin
            state_d = state_d;
        end
    end

    // Sequencer state, synchronisers and registered outputs; reset is a hard cut.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            idx_q        <= 4'd0;
            cnt_q        <= '0;
            en_q         <= '0;
            pg_meta_q    <= '0;
            pg_s_q       <= '0;
            power_good_q <= 1'b0;
            fault_q      <= 1'b0;
            fault_rail_q <= 4'd0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            en_q         <= en_d;
            pg_meta_q    <= pg_meta_d;
            pg_s_q       <= pg_s_d;
            power_good_q <= power_good_d;
            fault_q      <= fault_d;
            fault_rail_q <= fault_rail_d;
        end
    end

    assign bus.en         = en_q;
    assign bus.power_good = power_good_q;
    assign bus.fault      = fault_q;
    assign bus.fault_rail = fault_rail_q;
    assign bus.state      = state_q;

endmodule
